// File: rtl/bocks_text_blitter.sv
// Queued glyph/clear renderer driving the framebuffer pixel write port.
// Font RAM is loaded over ioctl; one pixel is emitted per accepted cycle.
module bocks_text_blitter #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 400,
   parameter int CHAR_W     = 8,
   parameter int CHAR_H     = 8,
   parameter int FIRST_CHAR = 32,
   parameter int NUM_CHARS  = 96,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 32,
   parameter int PIX_W      = 8
) (
   input  logic              pclk,
   input  logic              reset_n,
   input  logic              ioctl_wr,
   input  logic [26:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_clear,
   input  logic [6:0]        cmd_col,
   input  logic [6:0]        cmd_row,
   input  logic [7:0]        cmd_code,
   input  logic [PIX_W-1:0]  cmd_fg,
   input  logic [PIX_W-1:0]  cmd_bg,
   input  logic              fb_ready,
   output logic              cpu_wr,
   output logic [ADDR_W-1:0] cpu_addr,
   output logic [PIX_W-1:0]  cpu_data,
   output logic              busy,
   output logic              err_drop
);
   localparam int COLS       = SCREEN_W / CHAR_W;
   localparam int ROWS       = SCREEN_H / CHAR_H;
   localparam int FONT_BYTES = NUM_CHARS * CHAR_H;
   localparam int FA_W       = $clog2(FONT_BYTES);
   localparam int PW         = $clog2(FIFO_DEPTH);
   localparam int PTR_W      = PW + 1;
   localparam int XW         = $clog2(CHAR_W + 1);
   localparam int YW         = $clog2(CHAR_H + 1);
   localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(SCREEN_W);
   localparam logic [ADDR_W-1:0] CELL_H   = ADDR_W'(CHAR_H * SCREEN_W);
   localparam logic [ADDR_W-1:0] CELL_W   = ADDR_W'(CHAR_W);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(SCREEN_W * SCREEN_H - 1);
   localparam logic [XW-1:0]     X_LAST   = XW'(CHAR_W - 1);
   localparam logic [YW-1:0]     Y_LAST   = YW'(CHAR_H - 1);

   typedef struct packed {
      logic             clr;
      logic [6:0]       col;
      logic [6:0]       row;
      logic [7:0]       code;
      logic [PIX_W-1:0] fg;
      logic [PIX_W-1:0] bg;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE, S_FETCH, S_DRAW, S_CLEAR
   } state_t;

   cmd_t              fifo_mem [FIFO_DEPTH];
   logic [7:0]        font_mem [FONT_BYTES];
   cmd_t              cmd_in, head;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic              empty, full, push, pop;
   logic              rdy_q, rdy_d;
   state_t            state_q, state_d;
   cmd_t              cur_q, cur_d;
   logic [ADDR_W-1:0] addr_q, addr_d, line_q, line_d, base;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [FA_W-1:0]   faddr_q, faddr_d, font_ra, gaddr;
   logic              blank_q, blank_d, err_q, err_d;
   logic              font_re, in_font, pix_on;
   logic [7:0]        font_rd_q, bit_mask;

   assign cmd_in = {cmd_clear, cmd_col, cmd_row, cmd_code, cmd_fg, cmd_bg};
   assign head   = fifo_mem[rptr_q[PW-1:0]];
   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign cmd_ready = rdy_q && !full;
   assign push   = cmd_valid && cmd_ready;
   assign wptr_d = wptr_q + PTR_W'(push);
   assign rptr_d = rptr_q + PTR_W'(pop);
   assign rdy_d  = 1'b1;

   always_ff @(posedge pclk) begin
      if (push) fifo_mem[wptr_q[PW-1:0]] <= cmd_in;
   end

   // Font RAM has no reset so a redraw after reset reuses the loaded glyphs.
   always_ff @(posedge pclk) begin
      if (ioctl_wr && ioctl_addr < 27'(FONT_BYTES))
         font_mem[ioctl_addr[FA_W-1:0]] <= ioctl_dout;
      if (font_re) font_rd_q <= font_mem[font_ra];
   end

   assign in_font = (int'(cur_q.code) >= FIRST_CHAR) &&
                    (int'(cur_q.code) < FIRST_CHAR + NUM_CHARS);
   assign gaddr   = FA_W'((int'(cur_q.code) - FIRST_CHAR) * CHAR_H);
   assign base    = ADDR_W'(cur_q.row) * CELL_H + ADDR_W'(cur_q.col) * CELL_W;
   assign bit_mask = 8'(1 << (CHAR_W - 1)) >> x_q;
   assign pix_on  = |(font_rd_q & bit_mask) && !blank_q;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      addr_d  = addr_q;
      line_d  = line_q;
      x_d     = x_q;
      y_d     = y_q;
      faddr_d = faddr_q;
      blank_d = blank_q;
      err_d   = 1'b0;
      pop     = 1'b0;
      font_re = 1'b0;
      font_ra = faddr_q;
      if (!ioctl_wr) begin
         unique case (state_q)
            S_IDLE: if (!empty) begin
               pop   = 1'b1;
               cur_d = head;
               if (head.clr) begin
                  state_d = S_CLEAR;
                  addr_d  = '0;
               end else if (int'(head.col) >= COLS || int'(head.row) >= ROWS) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_FETCH: begin
               addr_d  = base;
               line_d  = base;
               x_d     = '0;
               y_d     = '0;
               blank_d = !in_font;
               font_ra = gaddr;
               faddr_d = gaddr;
               font_re = 1'b1;
               state_d = S_DRAW;
            end
            S_DRAW: if (fb_ready) begin
               if (x_q != X_LAST) begin
                  x_d    = x_q + XW'(1);
                  addr_d = addr_q + ADDR_W'(1);
               end else if (y_q != Y_LAST) begin
                  // Next font row lands with the first pixel of the next line.
                  x_d     = '0;
                  y_d     = y_q + YW'(1);
                  line_d  = line_q + STRIDE;
                  addr_d  = line_q + STRIDE;
                  font_ra = faddr_q + FA_W'(1);
                  faddr_d = font_ra;
                  font_re = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CLEAR: if (fb_ready) begin
               if (addr_q == LAST_PIX) state_d = S_IDLE;
               else addr_d = addr_q + ADDR_W'(1);
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         rdy_q   <= 1'b0;
         state_q <= S_IDLE;
         cur_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         faddr_q <= '0;
         blank_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         rdy_q   <= rdy_d;
         state_q <= state_d;
         cur_q   <= cur_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         x_q     <= x_d;
         y_q     <= y_d;
         faddr_q <= faddr_d;
         blank_q <= blank_d;
         err_q   <= err_d;
      end
   end

   assign cpu_wr   = (state_q == S_DRAW || state_q == S_CLEAR) && !ioctl_wr;
   assign cpu_addr = addr_q;
   assign cpu_data = (state_q == S_DRAW && pix_on) ? cur_q.fg : cur_q.bg;
   assign busy     = !empty || (state_q != S_IDLE);
   assign err_drop = err_q;
endmodule

// File: tb/tb_bocks_text_blitter.sv
// Directed + randomized bench for bocks_text_blitter on a 640x40 screen.
// Expected pixel streams come from a cell/font reference model.
module tb_bocks_text_blitter;
   localparam int SW = 640;
   localparam int SH = 40;
   localparam int NFONT = 768;

   logic        pclk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [26:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_clear = 1'b0;
   logic [6:0]  cmd_col = '0;
   logic [6:0]  cmd_row = '0;
   logic [7:0]  cmd_code = '0;
   logic [7:0]  cmd_fg = '0;
   logic [7:0]  cmd_bg = '0;
   logic        fb_ready = 1'b1;
   logic        cpu_wr;
   logic [31:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        busy;
   logic        err_drop;

   bocks_text_blitter #(.SCREEN_H(SH)) dut (
      .pclk(pclk), .reset_n(reset_n),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
      .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_code(cmd_code),
      .cmd_fg(cmd_fg), .cmd_bg(cmd_bg), .fb_ready(fb_ready),
      .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .busy(busy), .err_drop(err_drop)
   );

   initial forever #5 pclk = ~pclk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          err_cnt = 0;
   int          exp_err = 0;
   bit          rnd_fb = 1'b0;
   logic [7:0]  font [NFONT];
   logic [39:0] exp_q[$];
   logic [39:0] obs_q[$];

   initial forever begin
      @(negedge pclk);
      if (cpu_wr === 1'b1 && fb_ready === 1'b1) obs_q.push_back({cpu_addr, cpu_data});
      if (err_drop === 1'b1) err_cnt++;
   end

   initial forever begin
      @(posedge pclk);
      #1;
      if (rnd_fb) fb_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // Reference: pixel stream of one command, derived from cell geometry.
   task automatic model_cmd(input bit clr, input int col, input int row,
                            input int code, input logic [7:0] fg, input logic [7:0] bg);
      if (clr) begin
         for (int a = 0; a < SW * SH; a++) exp_q.push_back({32'(a), bg});
      end else if (col >= SW / 8 || row >= SH / 8) begin
         exp_err++;
      end else begin
         for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
               int  a;
               bit  on;
               a  = (row * 8 + y) * SW + col * 8 + x;
               on = 1'b0;
               if (code >= 32 && code < 128) on = font[(code - 32) * 8 + y][7 - x];
               exp_q.push_back({32'(a), on ? fg : bg});
            end
         end
      end
   endtask

   task automatic drive_cmd(input bit clr, input int col, input int row,
                            input int code, input logic [7:0] fg, input logic [7:0] bg);
      cmd_valid = 1'b1;
      cmd_clear = clr;
      cmd_col   = 7'(col);
      cmd_row   = 7'(row);
      cmd_code  = 8'(code);
      cmd_fg    = fg;
      cmd_bg    = bg;
      model_cmd(clr, col, row, code, fg, bg);
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic send_cmd(input bit clr, input int col, input int row,
                           input int code, input logic [7:0] fg, input logic [7:0] bg);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 5000) begin
         tick(1);
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
      drive_cmd(clr, col, row, code, fg, bg);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 60000) begin
         tick(1);
         n++;
      end
      chk({tag, "_idle"}, busy, 0);
      tick(2);
   endtask

   task automatic check_seq(input string tag);
      int bad = 0;
      int first = 0;
      int m;
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         if (obs_q[i] !== exp_q[i]) begin
            if (bad == 0) first = i;
            bad++;
         end
      end
      n_cmp++;
      assert (bad === 0) else begin
         n_bad++;
         $error("FAIL %s_data: %0d wrong, first #%0d observed %h expected %h",
                tag, bad, first, obs_q[first], exp_q[first]);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic font_wr(input int a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = 27'(a);
      ioctl_dout = d;
      tick(1);
      ioctl_wr   = 1'b0;
   endtask

   initial begin
      logic [7:0] glyph_a [8];
      int acc;
      glyph_a = '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};

      // reset values
      #12;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_cpu_wr", cpu_wr, 0);
      chk("rst_cpu_addr", cpu_addr, 0);
      chk("rst_cpu_data", cpu_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err_drop", err_drop, 0);
      @(posedge pclk);
      #1;
      reset_n = 1'b1;
      tick(1);
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // font load; 'A' glyph fixed, rest random
      for (int i = 0; i < NFONT; i++) begin
         font[i] = 8'($urandom);
         if (i >= 264 && i < 272) font[i] = glyph_a[i - 264];
         font_wr(i, font[i]);
      end
      // aliases glyph 0 row 0 if the range check were missing
      font_wr(1024, ~font[0]);

      // 'A' at cell 0,0 with first-write latency
      drive_cmd(1'b0, 0, 0, 8'h41, 8'hFF, 8'h00);
      chk("lat_e0_wr", cpu_wr, 0);
      tick(1);
      chk("lat_e1_wr", cpu_wr, 0);
      tick(1);
      chk("lat_e2_wr", cpu_wr, 1);
      chk("lat_e2_addr", cpu_addr, 0);
      chk("lat_e2_data", cpu_data, 8'h00);
      wait_idle("glyph_a");
      check_seq("glyph_a");

      // bottom-right cell
      send_cmd(1'b0, 79, SH / 8 - 1, 8'h5A, 8'hC3, 8'h21);
      wait_idle("corner");
      check_seq("corner");
      chk("corner_busy", busy, 0);

      // out-of-range column and row
      send_cmd(1'b0, 80, 0, 8'h41, 8'hFF, 8'h00);
      wait_idle("drop_col");
      chk("drop_col_err", err_cnt, exp_err);
      check_seq("drop_col");
      send_cmd(1'b0, 0, SH / 8, 8'h41, 8'hFF, 8'h00);
      wait_idle("drop_row");
      chk("drop_row_err", err_cnt, exp_err);
      check_seq("drop_row");

      // blank code, glyph 0 after aliased write, last glyph
      send_cmd(1'b0, 3, 1, 8'h1F, 8'h77, 8'h44);
      send_cmd(1'b0, 4, 2, 8'h20, 8'h99, 8'h11);
      send_cmd(1'b0, 5, 3, 8'h7F, 8'h5A, 8'hA5);
      send_cmd(1'b0, 6, 3, 8'h80, 8'h5A, 8'hA5);
      wait_idle("codes");
      check_seq("codes");

      // full clear
      send_cmd(1'b1, 0, 0, 0, 8'h00, 8'h12);
      wait_idle("clear");
      check_seq("clear");

      // fill FIFO with output stalled
      fb_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 40 && cmd_ready === 1'b1; i++) begin
         drive_cmd(1'b0, $urandom_range(0, 79), $urandom_range(0, SH / 8 - 1),
                   $urandom_range(20, 140), 8'($urandom), 8'($urandom));
         acc++;
      end
      chk("fill_accepted", acc, 17);
      tick(3);
      chk("stall_wr", cpu_wr, 1);
      chk("stall_addr", cpu_addr, exp_q[0][39:8]);
      chk("stall_data", cpu_data, exp_q[0][7:0]);
      tick(5);
      chk("stall_hold_addr", cpu_addr, exp_q[0][39:8]);
      chk("stall_obs", obs_q.size(), 0);
      rnd_fb = 1'b1;
      wait_idle("fill");
      rnd_fb = 1'b0;
      fb_ready = 1'b1;
      check_seq("fill");
      chk("fill_err", err_cnt, exp_err);

      // ioctl pulse during a draw freezes output
      send_cmd(1'b0, 10, 2, 8'h41, 8'hE7, 8'h18);
      tick(20);
      for (int i = 0; i < 3; i++) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = 27'(760 + i);
         ioctl_dout = 8'($urandom);
         font[760 + i] = ioctl_dout;
         #1;
         chk("ioctl_wr_low", cpu_wr, 0);
         tick(1);
      end
      ioctl_wr = 1'b0;
      wait_idle("ioctl");
      check_seq("ioctl");

      // reset mid-draw drops queued work, keeps font
      send_cmd(1'b0, 1, 1, 8'h41, 8'hFF, 8'h00);
      send_cmd(1'b0, 2, 1, 8'h42, 8'hFF, 8'h00);
      send_cmd(1'b0, 3, 1, 8'h43, 8'hFF, 8'h00);
      tick(10);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_wr", cpu_wr, 0);
      chk("mid_rst_busy", busy, 0);
      tick(2);
      obs_q.delete();
      exp_q.delete();
      reset_n = 1'b1;
      tick(6);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_obs", obs_q.size(), 0);
      send_cmd(1'b0, 0, 0, 8'h41, 8'hFF, 8'h00);
      wait_idle("redraw");
      check_seq("redraw");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bocks_text_blitter.md
Name: bocks_text_blitter

Overview:
- Command-driven glyph renderer feeding the vga framebuffer write port (cpu_wr/cpu_addr/cpu_data).
- Replaces the fixed dump of the whole font with queued per-cell draw requests: column, row, character code, foreground colour and background colour.
- Also supports a full-screen clear command.
- Font RAM is loaded over the ioctl download port; screen and glyph geometry are parametrised.

Parameters:
SCREEN_W, 640, framebuffer width in pixels
SCREEN_H, 400, framebuffer height in pixels
CHAR_W, 8, glyph width in pixels (1..8)
CHAR_H, 8, glyph height in rows
FIRST_CHAR, 32, character code of font glyph 0
NUM_CHARS, 96, glyphs in font RAM (font RAM = NUM_CHARS*CHAR_H bytes)
FIFO_DEPTH, 16, command FIFO entries (power of two)
ADDR_W, 32, cpu_addr width
PIX_W, 8, cpu_data width
Derived: COLS=SCREEN_W/CHAR_W (80), ROWS=SCREEN_H/CHAR_H (50)

Ports:
pclk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ioctl_wr  in  1  font byte write strobe
ioctl_addr  in  27  font byte address
ioctl_dout  in  8  font byte; bit CHAR_W-1 = leftmost pixel
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_clear  in  1  1 = clear screen to cmd_bg; col/row/code ignored
cmd_col  in  7  cell column
cmd_row  in  7  cell row
cmd_code  in  8  character code
cmd_fg  in  PIX_W  pixel value for set font bits
cmd_bg  in  PIX_W  pixel value for clear font bits
fb_ready  in  1  framebuffer accepts write this cycle
cpu_wr  out  1  framebuffer write valid
cpu_addr  out  ADDR_W  linear pixel address
cpu_data  out  PIX_W  pixel value
busy  out  1  FIFO non-empty or FSM not IDLE
err_drop  out  1  one-cycle pulse: command discarded as out of range

Behaviour:
- Reset (async assert, sync release): FIFO empty; FSM IDLE; cpu_wr=0, cpu_addr=0, cpu_data=0, err_drop=0, busy=0. cmd_ready=0 while reset_n low, 1 from the first clock edge after release.
- Reset mid-draw aborts the draw and flushes the FIFO. Font RAM contents are preserved.
- Font load: ioctl_wr writes ioctl_dout to font RAM[ioctl_addr]. Addresses >= NUM_CHARS*CHAR_H are ignored.
- While ioctl_wr=1 the FSM freezes (no state/counter/address advance) and cpu_wr is forced 0. The FIFO still accepts commands.
- FIFO push on cmd_valid&&cmd_ready. Simultaneous push and pop on a full FIFO is not allowed: cmd_ready depends on full only.
- FSM states:
  - IDLE: if FIFO non-empty and no ioctl_wr, pop.
    - Clear command -> CLEAR.
    - Glyph with col>=COLS or row>=ROWS -> err_drop pulse next cycle, stay IDLE, no writes.
    - Otherwise -> FETCH.
  - FETCH: base=row*CHAR_H*SCREEN_W+col*CHAR_W. Glyph index g=code-FIRST_CHAR if FIRST_CHAR<=code<FIRST_CHAR+NUM_CHARS, else blank (all bg). Issue font read of row 0 at g*CHAR_H (1-cycle read latency) -> DRAW.
  - DRAW: one pixel per accepted cycle.
    - Pixel (x,y): addr=base+y*SCREEN_W+x; data=fg if font bit CHAR_W-1-x is set, else bg.
    - x runs 0..CHAR_W-1, then y+1. Next row's font byte is prefetched so lines are contiguous with no bubbles.
    - After pixel (CHAR_W-1, CHAR_H-1) is accepted -> IDLE.
  - CLEAR: addr 0..SCREEN_W*SCREEN_H-1 ascending, data=bg, one per accepted cycle, then -> IDLE.
- Output handshake: a write is accepted when cpu_wr&&fb_ready. While fb_ready=0, cpu_wr/cpu_addr/cpu_data hold unchanged.
- Timing with fb_ready=1, no ioctl_wr:
  - Command accepted into an empty FIFO at edge E0 -> popped at E1 -> first cpu_wr high after E2 (2-cycle latency to first write).
  - A glyph takes 2+CHAR_W*CHAR_H cycles; back-to-back glyphs have a 2-cycle write gap.
- Address arithmetic is performed at ADDR_W bits; with the defaults no overflow occurs.

Test Plan:
- Load 768-byte font, glyph 'A' (0x41) rows = 0x18,0x3C,0x66,0x7E,0x66,0x66,0x66,0x00; draw col0,row0, fg 0xFF, bg 0x00 -> exactly 64 writes at addrs 0-7, 640-647, ..., 4480-4487. Row 0 data: 00,00,00,FF,FF,00,00,00. Last row all 00.
- Draw col79,row49 -> first addr 251512, last addr 255999, 64 writes, then busy falls.
- cmd_col=80 (and separately cmd_row=50) -> err_drop high exactly 1 cycle, zero cpu_wr, FSM returns IDLE.
- cmd_clear, bg 0x12 -> 256000 writes, addrs 0..255999 ascending, all data 0x12. cmd_code 0x1F drawn -> 64 writes all bg.
- fb_ready held 0, push until cmd_ready=0 -> 17 commands accepted (1 in FSM, 16 in FIFO), outputs frozen. Release fb_ready -> 17*64 writes in push order. Toggling fb_ready randomly -> identical write sequence.
- ioctl_wr pulsed mid-draw -> cpu_wr 0 during the pulse, draw resumes with no skipped pixel. reset_n pulled low mid-draw -> cpu_wr 0 immediately, busy 0, queued commands lost, font retained (redraw matches).
